// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed response latency
// One outstanding request; request is captured at acceptance and serviced when the latency expires.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    count;
  logic          cap_we;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          addr_err;
  logic [AW-1:0] word_idx;
  logic          service;

  assign req_ready = (state == S_IDLE);
  assign addr_err  = (cap_addr[1:0] != 2'b00) ||
                     ({2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign word_idx  = cap_addr[AW+1:2];
  // The edge that enters RESP is the single point where the array is touched.
  assign service   = (state == S_WAIT) && (count == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= 4'd0;
      cap_we     <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            count     <= 4'(LATENCY - 1);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (count == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
            resp_rdata <= (!addr_err && !cap_we) ? mem[word_idx] : 32'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; a reset clears state, so no commit can follow it.
  always_ff @(posedge clk) begin
    if (service && cap_we && !addr_err) begin
      mem[word_idx] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
// Reference model: flat word array plus known-flags, error rule from address arithmetic.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_valid = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
  logic        r1_ready, r1_rvalid, r1_err;
  logic [31:0] r1_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_we(r1_we), .req_addr(r1_addr), .req_wdata(r1_wdata),
    .resp_valid(r1_rvalid), .resp_ready(1'b1),
    .resp_rdata(r1_rdata), .resp_err(r1_err)
  );

  function automatic bit exp_err(input logic [31:0] a, input int depth);
    return (a % 4 != 0) || ((a / 4) >= depth);
  endfunction

  // Issue one request, wait for the response, compare against the model, then retire it.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input string tag);
    int lat;
    bit e;
    logic [31:0] exp_d;
    bit check_d;
    e = exp_err(a, DEPTH);
    check_d = 1'b1;
    if (e || we) exp_d = 32'd0;
    else if (known[a / 4]) exp_d = ref_mem[a / 4];
    else begin exp_d = 32'd0; check_d = 1'b0; end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready before accept got %b want 1", tag, req_ready); end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, LAT); end
    checks++;
    if (resp_err !== e) begin errors++; $display("FAIL %s resp_err got %b want %b addr %h", tag, resp_err, e, a); end
    if (check_d) begin
      checks++;
      if (resp_rdata !== exp_d) begin errors++; $display("FAIL %s resp_rdata got %h want %h addr %h", tag, resp_rdata, exp_d, a); end
    end
    if (we && !e) begin ref_mem[a / 4] = wd; known[a / 4] = 1'b1; end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s retire got valid %b ready %b want 0 1", tag, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL reset got ready %b valid %b rdata %h err %b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_req(1'b1, 32'h10, 32'hDEADBEEF, "sw_10");
    do_req(1'b0, 32'h10, 32'h0, "lw_10");
    do_req(1'b1, 32'h0, 32'hCAFEF00D, "sw_0");
    do_req(1'b0, 32'h13, 32'h0, "lw_misaligned");
    do_req(1'b1, 32'h4002, 32'hBAD0BAD0, "sw_out_of_range");
    do_req(1'b1, 32'h1000, 32'hBAD1BAD1, "sw_word_1024");
    do_req(1'b0, 32'h0, 32'h0, "lw_0_unchanged");
    do_req(1'b1, 32'hFFC, 32'h0F0F0F0F, "sw_last_word");
    do_req(1'b0, 32'hFFC, 32'h0, "lw_last_word");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) a = ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
      else if (kind == 1) a = {$urandom_range(1024, 32'h3FFF_FFFF), 2'b00};
      else a = $urandom_range(0, 63) * 4;
      do_req($urandom_range(0, 1) == 1, a, $urandom, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_d;
    logic        held_e;
    int lat;
    do_req(1'b1, 32'h40, 32'h5A5A1234, "bp_setup");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h5A5A1234) begin
      errors++; $display("FAIL bp_first got valid %b rdata %h want 1 5a5a1234", resp_valid, resp_rdata);
    end
    held_d = resp_rdata; held_e = resp_err;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BAD0BAD;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== held_d || resp_err !== held_e || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold got valid %b rdata %h err %b ready %b want 1 %h %b 0", resp_valid, resp_rdata, resp_err, req_ready, held_d, held_e);
      end
    end
    @(negedge clk); req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid %b ready %b want 0 1", resp_valid, req_ready);
    end
    do_req(1'b0, 32'h40, 32'h0, "bp_ignored_store");
  endtask

  task automatic test_reset_wait();
    int seen;
    do_req(1'b1, 32'h20, 32'h11111111, "rw_setup");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rw_async got ready %b valid %b want 1 0", req_ready, resp_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (resp_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rw_no_resp got %0d valid cycles want 0", seen); end
    do_req(1'b0, 32'h20, 32'h0, "rw_not_committed");
  endtask

  task automatic test_latency1();
    int lat;
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      for (int we = 1; we >= 0; we--) begin
        @(negedge clk);
        r1_valid = 1'b1; r1_we = (we == 1); r1_addr = 32'(k * 4); r1_wdata = d;
        @(posedge clk); #1;
        r1_valid = 1'b0;
        lat = 0;
        while (r1_rvalid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL lat1_latency got %0d want 1", lat); end
        checks++;
        if (r1_err !== 1'b0 || r1_rdata !== ((we == 1) ? 32'd0 : d)) begin
          errors++; $display("FAIL lat1_data got err %b rdata %h want 0 %h", r1_err, r1_rdata, (we == 1) ? 32'd0 : d);
        end
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 32'h40;
    @(posedge clk); #1;
    r1_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (r1_rvalid !== 1'b1 || r1_err !== 1'b1 || r1_rdata !== 32'd0) begin
      errors++; $display("FAIL lat1_range got valid %b err %b rdata %h want 1 1 0", r1_rvalid, r1_err, r1_rdata);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_wait();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
